// File: rtl/timer_bcd.sv
// Four-digit BCD countdown timer (MM:SS) loaded digit-by-digit from a keypad encoder.
// Optional macro TIMER_DONE_PULSE_EN makes done a one-cycle pulse instead of a level.
module timer_bcd (
   input  logic       clk,
   input  logic       clear,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1Hz,
   input  logic       run,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       zero,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] digits_q, digits_d;
   logic [15:0] dec_val;
   logic        loadn_q, pgt_q;
   logic        clr_q;
   logic        done_q, done_d;
   logic        load_ev, tick_ev, dec_zero;

   // clr_q masks the first cycle after clear so a loadn held low needs a fresh fall.
   assign load_ev = loadn_q & ~loadn & ~clr_q;
   assign tick_ev = ~pgt_q & pgt_1Hz;

   assign sec_ones = digits_q[3:0];
   assign sec_tens = digits_q[7:4];
   assign min_ones = digits_q[11:8];
   assign min_tens = digits_q[15:12];
   assign zero     = (digits_q == 16'h0000);
   assign busy     = (state_q == StRun);

   always_comb begin
      dec_val = digits_q;
      if (digits_q[3:0] != 4'd0) begin
         dec_val[3:0] = digits_q[3:0] - 4'd1;
      end else begin
         dec_val[3:0] = 4'd9;
         if (digits_q[7:4] != 4'd0) begin
            dec_val[7:4] = digits_q[7:4] - 4'd1;
         end else begin
            dec_val[7:4] = 4'd5;
            if (digits_q[11:8] != 4'd0) begin
               dec_val[11:8] = digits_q[11:8] - 4'd1;
            end else begin
               dec_val[11:8]  = 4'd9;
               dec_val[15:12] = digits_q[15:12] - 4'd1;
            end
         end
      end
      dec_zero = (dec_val == 16'h0000);
   end

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      done_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (load_ev && (D <= 4'd9)) begin
               digits_d = {digits_q[11:0], D};
            end
            if (run && !zero) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (!run) begin
               state_d = StIdle;
            end else if (tick_ev) begin
               digits_d = dec_val;
               if (dec_zero) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end
         end
         StDone: begin
            if (!run) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q  <= StIdle;
         digits_q <= 16'h0000;
         loadn_q  <= 1'b1;
         pgt_q    <= 1'b0;
         clr_q    <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         loadn_q  <= loadn;
         pgt_q    <= pgt_1Hz;
         clr_q    <= 1'b0;
         done_q   <= done_d;
      end
   end

`ifdef TIMER_DONE_PULSE_EN
   assign done = done_q;
`else
   assign done = (state_q == StDone);
   logic unused_done_q;
   assign unused_done_q = done_q;
`endif

endmodule

// File: doc/timer_bcd.md
TIMER_BCD -- requirements
Module: timer_bcd

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port clear, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port D, input, 4 bits: BCD digit from the keypad encoder.
REQ-004 The block SHALL have the port loadn, input, 1 bit: active-low digit-valid strobe from the keypad encoder.
REQ-005 The block SHALL have the port pgt_1Hz, input, 1 bit: 1 Hz tick from the encoder, sampled as data on clk.
REQ-006 The block SHALL have the port run, input, 1 bit: count-down request; 1 means count, 0 means pause or load.
REQ-007 The block SHALL have the port sec_ones, output, 4 bits: BCD seconds units.
REQ-008 The block SHALL have the port sec_tens, output, 4 bits: BCD seconds tens.
REQ-009 The block SHALL have the port min_ones, output, 4 bits: BCD minutes units.
REQ-010 The block SHALL have the port min_tens, output, 4 bits: BCD minutes tens.
REQ-011 The block SHALL have the port zero, output, 1 bit: all four digits equal 0.
REQ-012 The block SHALL have the port busy, output, 1 bit: FSM is in RUN.
REQ-013 The block SHALL have the port done, output, 1 bit: countdown completed (see REQ-029).

Function
REQ-014 The block SHALL register loadn and pgt_1Hz once, for edge detection only.
REQ-015 A load event SHALL be defined as loadn sampled 1 on the previous clk and 0 on the current clk (falling edge); a held-low loadn SHALL yield exactly one load.
REQ-016 A tick event SHALL be defined as pgt_1Hz rising from 0 to 1 between consecutive clk samples.
REQ-017 The FSM SHALL have 3 states: IDLE, RUN and DONE.
REQ-018 In IDLE, a load event with D<=9 SHALL shift digits left in one cycle: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
REQ-019 A load event with D>9 SHALL be ignored; digits unchanged.
REQ-020 Load events in RUN or DONE SHALL be ignored.
REQ-021 IDLE SHALL go to RUN when run=1 and zero=0; with run=1 and zero=1 it SHALL stay in IDLE.
REQ-022 In RUN, each tick event SHALL decrement the 4-digit value by one second, with the new value visible the cycle after the edge is detected.
REQ-023 Decrement rules: sec_ones 0 borrows and becomes 9; sec_tens 0 borrows and becomes 5; min_ones 0 borrows and becomes 9; min_tens decrements on a borrow from min_ones.
REQ-024 A sec_tens value of 6-9 entered by keypad SHALL decrement normally with no clamping; only wrap-from-0 yields 5.
REQ-025 RUN SHALL go to DONE on the cycle the decrement produces 00:00; there is no decrement below zero.
REQ-026 RUN SHALL go to IDLE when run=0 (pause), with digits held; a tick in the same cycle SHALL be ignored.
REQ-027 DONE SHALL go to IDLE when run=0; digits stay 00:00.
REQ-028 zero SHALL be combinational from the digit registers; busy SHALL be 1 only in RUN.
REQ-029 done SHALL follow REQ-038 when the Configuration macro is defined, and REQ-039 when it is not.
REQ-030 When a tick event and a load event coincide in RUN, the block SHALL decrement only.
REQ-031 Maximum value SHALL be 99:59 from normal entry; 99:99 entry SHALL be legal and counts down per REQ-023.

Reset
REQ-032 clear=1 at a clk edge SHALL force state to IDLE, all digits to 0, done=0 and both edge registers to 1 (loadn) and 0 (pgt_1Hz).
REQ-033 clear SHALL take priority over tick, load and run in the same cycle, including mid-RUN.
REQ-034 After clear is released, a loadn already low SHALL NOT produce a load until it rises and falls again.
REQ-035 Output values after reset SHALL be: zero=1, busy=0, done=0.

Configuration
REQ-036 The block SHALL use the macro TIMER_DONE_PULSE_EN.
REQ-037 The macro SHALL affect only the done output.
REQ-038 With TIMER_DONE_PULSE_EN defined, done SHALL be a one-clk pulse on the RUN->DONE transition.
REQ-039 Without TIMER_DONE_PULSE_EN, done SHALL equal 1 for the whole time the FSM is in DONE.

Verification
REQ-040 Entry: clear; load 1,3,0 -> digits 01:30, zero=0; then load D=12 -> unchanged.
REQ-041 Borrow chain: load 1,0,0,0 (10:00), run=1, 1 tick -> 09:59; another tick -> 09:58.
REQ-042 Completion: 00:02, run=1, 2 ticks -> 00:00, zero=1, state DONE, done per macro (1-cycle pulse vs level); run=0 -> IDLE, done=0.
REQ-043 Pause and collision: 00:45 running, drop run=0 with a tick in the same cycle -> 00:45 held, busy=0; a load during RUN is ignored.
REQ-044 Reset mid-run: 05:00 running, assert clear with a tick -> 00:00, IDLE, done=0; a held-low loadn produces no load after release.
REQ-045 Zero start: 00:00, run=1 -> stays in IDLE, busy=0, done=0.
